// File: rtl/re_velocity_solve_if.sv
// Handshake bundle between the velocity solver and its neighbours: tensor
// input channel, result output channel, and the solved velocity fields.
interface re_velocity_solve_if #(
  parameter int TENSOR_WIDTH = 14
);
  logic                           in_valid;
  logic                           in_ready;
  logic [6*TENSOR_WIDTH-1:0]      tensors_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [6*TENSOR_WIDTH-1:0]      tensors_out;
  logic signed [TENSOR_WIDTH-1:0] vx;
  logic signed [TENSOR_WIDTH-1:0] vy;
  logic                           singular;
  logic                           saturated;

  modport master (
    output in_valid, tensors_in, out_ready,
    input  in_ready, out_valid, tensors_out, vx, vy, singular, saturated
  );

  modport slave (
    input  in_valid, tensors_in, out_ready,
    output in_ready, out_valid, tensors_out, vx, vy, singular, saturated
  );
endinterface

// File: rtl/re_velocity_solve.sv
// Solves the 2x2 structure-tensor normal equations for (vx, vy) using two
// restoring dividers sharing the determinant, one transaction at a time.
module re_velocity_solve #(
  parameter int TENSOR_WIDTH = 14,
  parameter int FRAC_BITS    = TENSOR_WIDTH / 2,
  parameter int MIN_DET      = 1,
  parameter int DIV_CYCLES   = 2 * TENSOR_WIDTH + 1 + FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  re_velocity_solve_if.slave   bus
);
  localparam int TW = TENSOR_WIDTH;
  localparam int PW = 2 * TW + 1;
  localparam int NW = DIV_CYCLES;
  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [CW-1:0]        CNT_LAST  = CW'(DIV_CYCLES - 1);
  localparam logic signed [PW-1:0] MIN_DET_W = PW'(MIN_DET);
  localparam logic [NW-1:0]        QMAX      = {{(NW - TW + 1){1'b0}}, {(TW - 1){1'b1}}};
  localparam logic [TW-1:0]        QMAX_TW   = {1'b0, {(TW - 1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DET, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;

  logic [6*TW-1:0]        tensors_q;
  logic signed [PW-1:0]   p_xxyy_q, p_xyxy_q, p_xyyt_q, p_yyxt_q, p_xyxt_q, p_xxyt_q;
  logic [PW-1:0]          det_q;
  logic signed [PW-1:0]   det_c;
  logic                   det_small;
  logic [CW-1:0]          cnt_q;
  logic                   div_last;
  logic                   singular_q, saturated_q;
  logic [1:0]             clamp_ch;

  logic signed [TW-1:0] t_xx, t_xy, t_xt, t_yy, t_yt;
  assign t_xx = tensors_q[6*TW-1 -: TW];
  assign t_xy = tensors_q[5*TW-1 -: TW];
  assign t_xt = tensors_q[4*TW-1 -: TW];
  assign t_yy = tensors_q[3*TW-1 -: TW];
  assign t_yt = tensors_q[2*TW-1 -: TW];

  // Full-width signed product; operands are sign-extended before multiplying.
  function automatic logic signed [PW-1:0] smul(input logic signed [TW-1:0] a,
                                                input logic signed [TW-1:0] b);
    logic signed [PW-1:0] ae, be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  assign det_c     = p_xxyy_q - p_xyxy_q;
  assign det_small = det_c < MIN_DET_W;
  assign div_last  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_MUL;
      S_MUL:   state_d = S_DET;
      S_DET:   state_d = det_small ? S_DONE : S_DIV;
      S_DIV:   if (div_last) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.tensors_out = tensors_q;
  assign bus.singular    = singular_q;
  assign bus.saturated   = saturated_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tensors_q   <= '0;
      p_xxyy_q    <= '0;
      p_xyxy_q    <= '0;
      p_xyyt_q    <= '0;
      p_yyxt_q    <= '0;
      p_xyxt_q    <= '0;
      p_xxyt_q    <= '0;
      det_q       <= '0;
      cnt_q       <= '0;
      singular_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) tensors_q <= bus.tensors_in;
        S_MUL: begin
          p_xxyy_q <= smul(t_xx, t_yy);
          p_xyxy_q <= smul(t_xy, t_xy);
          p_xyyt_q <= smul(t_xy, t_yt);
          p_yyxt_q <= smul(t_yy, t_xt);
          p_xyxt_q <= smul(t_xy, t_xt);
          p_xxyt_q <= smul(t_xx, t_yt);
        end
        S_DET: begin
          det_q <= det_c;
          cnt_q <= '0;
          if (det_small) begin
            singular_q  <= 1'b1;
            saturated_q <= 1'b0;
          end
        end
        S_DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (div_last) begin
            singular_q  <= 1'b0;
            saturated_q <= |clamp_ch;
          end
        end
        default: ;
      endcase
    end
  end

  // Channel 0 solves vx from nx, channel 1 solves vy from ny; both divide by det.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [PW-1:0] n_c;
      logic [PW-1:0]        abs_c;
      logic [NW-1:0]        num_q, quot_q, quot_d;
      logic [PW-1:0]        rem_q, rem_d, rem_sh;
      logic                 fits;
      logic                 neg_q;
      logic [TW-1:0]        mag_c;
      logic signed [TW-1:0] v_q, v_d;

      if (gi == 0) begin : g_nx
        assign n_c = p_xyyt_q - p_yyxt_q;
      end else begin : g_ny
        assign n_c = p_xyxt_q - p_xxyt_q;
      end

      assign abs_c  = n_c[PW-1] ? -n_c : n_c;
      assign rem_sh = {rem_q[PW-2:0], num_q[NW-1]};
      assign fits   = (rem_sh >= det_q);
      assign rem_d  = fits ? (rem_sh - det_q) : rem_sh;
      assign quot_d = {quot_q[NW-2:0], fits};

      // Symmetric clamp on the magnitude, then the sign is reapplied.
      assign clamp_ch[gi] = (quot_d > QMAX);
      assign mag_c        = clamp_ch[gi] ? QMAX_TW : quot_d[TW-1:0];
      assign v_d          = neg_q ? -$signed(mag_c) : $signed(mag_c);

      always_ff @(posedge clk) begin
        if (rst) begin
          num_q  <= '0;
          quot_q <= '0;
          rem_q  <= '0;
          neg_q  <= 1'b0;
          v_q    <= '0;
        end else begin
          case (state_q)
            S_DET: begin
              num_q  <= NW'({abs_c, {FRAC_BITS{1'b0}}});
              neg_q  <= n_c[PW-1];
              rem_q  <= '0;
              quot_q <= '0;
              if (det_small) v_q <= '0;
            end
            S_DIV: begin
              num_q  <= {num_q[NW-2:0], 1'b0};
              rem_q  <= rem_d;
              quot_q <= quot_d;
              if (div_last) v_q <= v_d;
            end
            default: ;
          endcase
        end
      end

      if (gi == 0) begin : g_out_x
        assign bus.vx = v_q;
      end else begin : g_out_y
        assign bus.vy = v_q;
      end
    end
  endgenerate
endmodule

// File: tb/tb_re_velocity_solve.sv
// Directed scenarios for the velocity solver with hand-computed results.
module tb_re_velocity_solve;
  localparam int TW     = 14;
  localparam int LAT_NS = 39;
  localparam int LAT_S  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  re_velocity_solve_if #(.TENSOR_WIDTH(TW)) bus_if ();

  re_velocity_solve #(.TENSOR_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [6*TW-1:0] pack6(input int xx, input int xy, input int xt,
                                            input int yy, input int yt, input int tt);
    return {TW'(xx), TW'(xy), TW'(xt), TW'(yy), TW'(yt), TW'(tt)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one word and waits (bounded) for out_valid; lat counts the accept edge as 1.
  task automatic run_txn(input logic [6*TW-1:0] t, input string name, output int lat);
    int w;
    w = 0;
    while (bus_if.in_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    bus_if.tensors_in = t;
    bus_if.in_valid   = 1'b1;
    tick();
    bus_if.in_valid   = 1'b0;
    lat = 1;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    $display("txn %s: lat=%0d vx=%0d vy=%0d singular=%b saturated=%b",
             name, lat, bus_if.vx, bus_if.vy, bus_if.singular, bus_if.saturated);
  endtask

  task automatic handshake;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", bus_if.in_ready, bus_if.out_valid);
    end
    checks++;
    if (bus_if.vx !== '0 || bus_if.vy !== '0) begin
      errors++;
      $display("FAIL reset_v: vx=%0d vy=%0d expected 0/0", bus_if.vx, bus_if.vy);
    end
    checks++;
    if (bus_if.singular !== 1'b0 || bus_if.saturated !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: singular=%b saturated=%b expected 0/0", bus_if.singular, bus_if.saturated);
    end
    checks++;
    if (bus_if.tensors_out !== '0) begin
      errors++;
      $display("FAIL reset_tensors: got %h expected 0", bus_if.tensors_out);
    end
  endtask

  task automatic test_basic;
    logic [6*TW-1:0] t;
    int lat;
    t = pack6(100, 0, -50, 100, 25, 7);
    run_txn(t, "basic", lat);
    checks++;
    if (lat !== LAT_NS) begin errors++; $display("FAIL basic_lat: got %0d expected %0d", lat, LAT_NS); end
    checks++;
    if (bus_if.vx !== TW'(64)) begin errors++; $display("FAIL basic_vx: got %0d expected 64", bus_if.vx); end
    checks++;
    if (bus_if.vy !== TW'(-32)) begin errors++; $display("FAIL basic_vy: got %0d expected -32", bus_if.vy); end
    checks++;
    if (bus_if.singular !== 1'b0 || bus_if.saturated !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: singular=%b saturated=%b expected 0/0", bus_if.singular, bus_if.saturated);
    end
    checks++;
    if (bus_if.tensors_out !== t) begin errors++; $display("FAIL basic_tensors: got %h expected %h", bus_if.tensors_out, t); end
    checks++;
    if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: in_ready=%b expected 0", bus_if.in_ready); end
    handshake();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b expected 1/0", bus_if.in_ready, bus_if.out_valid);
    end
  endtask

  task automatic test_singular;
    int lat;
    run_txn(pack6(10, 10, 5, 10, 0, 0), "singular", lat);
    checks++;
    if (lat !== LAT_S) begin errors++; $display("FAIL sing_lat: got %0d expected %0d", lat, LAT_S); end
    checks++;
    if (bus_if.vx !== '0 || bus_if.vy !== '0) begin
      errors++;
      $display("FAIL sing_v: vx=%0d vy=%0d expected 0/0", bus_if.vx, bus_if.vy);
    end
    checks++;
    if (bus_if.singular !== 1'b1 || bus_if.saturated !== 1'b0) begin
      errors++;
      $display("FAIL sing_flags: singular=%b saturated=%b expected 1/0", bus_if.singular, bus_if.saturated);
    end
    handshake();
    checks++;
    if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL sing_release: in_ready=%b expected 1", bus_if.in_ready); end
  endtask

  task automatic test_saturate;
    int lat;
    run_txn(pack6(1, 0, -8000, 1, 0, 0), "sat_pos", lat);
    checks++;
    if (bus_if.vx !== TW'(8191) || bus_if.vy !== '0) begin
      errors++;
      $display("FAIL satp_v: vx=%0d vy=%0d expected 8191/0", bus_if.vx, bus_if.vy);
    end
    checks++;
    if (bus_if.saturated !== 1'b1 || bus_if.singular !== 1'b0) begin
      errors++;
      $display("FAIL satp_flags: saturated=%b singular=%b expected 1/0", bus_if.saturated, bus_if.singular);
    end
    handshake();
    run_txn(pack6(1, 0, 8000, 1, 0, 0), "sat_neg", lat);
    checks++;
    if (bus_if.vx !== TW'(-8191) || bus_if.vy !== '0) begin
      errors++;
      $display("FAIL satn_v: vx=%0d vy=%0d expected -8191/0", bus_if.vx, bus_if.vy);
    end
    checks++;
    if (bus_if.saturated !== 1'b1) begin errors++; $display("FAIL satn_flag: saturated=%b expected 1", bus_if.saturated); end
    handshake();
  endtask

  task automatic test_truncation;
    int lat;
    run_txn(pack6(3, 0, -1, 3, 1, 0), "trunc", lat);
    checks++;
    if (bus_if.vx !== TW'(42)) begin errors++; $display("FAIL trunc_vx: got %0d expected 42", bus_if.vx); end
    checks++;
    if (bus_if.vy !== TW'(-42)) begin errors++; $display("FAIL trunc_vy: got %0d expected -42", bus_if.vy); end
    checks++;
    if (bus_if.saturated !== 1'b0) begin errors++; $display("FAIL trunc_sat: got %b expected 0", bus_if.saturated); end
    handshake();
  endtask

  task automatic test_backpressure;
    logic [6*TW-1:0] t;
    int lat;
    int bad;
    t = pack6(100, 0, -50, 100, 25, 7);
    run_txn(t, "backpressure", lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus_if.tensors_in = pack6(1, 2, 3, 4, 5, 6);
      bus_if.in_valid   = 1'b1;
      tick();
      if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.vx !== TW'(64) ||
          bus_if.vy !== TW'(-32) || bus_if.tensors_out !== t || bus_if.singular !== 1'b0 ||
          bus_if.saturated !== 1'b0)
        bad++;
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles expected 0", bad); end
    handshake();
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", bus_if.out_valid, bus_if.in_ready);
    end
    tick();
    tick();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: in_ready=%b out_valid=%b expected 1/0", bus_if.in_ready, bus_if.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    bus_if.tensors_in = pack6(3, 0, -1, 3, 1, 0);
    bus_if.in_valid   = 1'b1;
    tick();
    bus_if.in_valid   = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus_if.vx !== '0 || bus_if.vy !== '0 || bus_if.tensors_out !== '0) begin
      errors++;
      $display("FAIL rmid_values: vx=%0d vy=%0d tensors=%h expected zeros", bus_if.vx, bus_if.vy, bus_if.tensors_out);
    end
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.singular !== 1'b0 || bus_if.saturated !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ctrl: in_ready=%b out_valid=%b singular=%b saturated=%b expected 1/0/0/0",
               bus_if.in_ready, bus_if.out_valid, bus_if.singular, bus_if.saturated);
    end
    seen = 0;
    repeat (45) begin
      tick();
      if (bus_if.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rmid_ghost: out_valid seen %0d cycles expected 0", seen); end
    run_txn(pack6(100, 0, -50, 100, 25, 7), "after_reset", lat);
    checks++;
    if (lat !== LAT_NS || bus_if.vx !== TW'(64) || bus_if.vy !== TW'(-32)) begin
      errors++;
      $display("FAIL rmid_next: lat=%0d vx=%0d vy=%0d expected %0d/64/-32", lat, bus_if.vx, bus_if.vy, LAT_NS);
    end
    handshake();
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.out_ready  = 1'b0;
    bus_if.tensors_in = '0;
    test_reset();
    test_basic();
    test_singular();
    test_saturate();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/re_velocity_solve.md
# re_velocity_solve

Per-pixel least-squares velocity solver for the recursive-estimation optical-flow pipeline. It sits directly upstream of the k (error-variance) calculation stage. It takes the six packed structure-tensor components and solves the 2×2 normal equations for (vx, vy) in fixed point. It forwards the tensors with the result so the downstream stage receives aligned `tensors`, `vx` and `vy`.

## Interface
- TENSOR_WIDTH, 14, signed width of each tensor component and of vx/vy.
- FRAC_BITS, TENSOR_WIDTH/2, fractional bits of vx/vy. 1.0 = 2^FRAC_BITS.
- MIN_DET, 1, determinant below this is treated as singular.
- DIV_CYCLES, 2*TENSOR_WIDTH+1+FRAC_BITS, restoring-divider iterations (numerator magnitude width).

Ports:
- clk  in  1  clock. One clock domain; all logic is on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- in_valid  in  1  tensor word valid.
- in_ready  out  1  block can accept. High only in IDLE.
- tensors_in  in  6*TENSOR_WIDTH  packed {xx,xy,xt,yy,yt,tt}, xx in the MSBs, tt at [TENSOR_WIDTH-1:0]. Each field is signed.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- tensors_out  out  6*TENSOR_WIDTH  copy of the accepted tensors_in.
- vx, vy  out  TENSOR_WIDTH each  signed velocity, FRAC_BITS fractional.
- singular  out  1  det < MIN_DET. vx = vy = 0 when set.
- saturated  out  1  vx or vy was clamped.

## Operation
- Equations: det = xx·yy − xy²; nx = xy·yt − yy·xt; ny = xy·xt − xx·yt.
  - vx = (nx·2^FRAC_BITS)/det; vy = (ny·2^FRAC_BITS)/det.
  - All products use full signed width, 2*TENSOR_WIDTH+1 bits. No intermediate truncation.
- FSM states: IDLE, MUL, DET, DIV, DONE.
- IDLE: in_ready = 1.
  - On in_valid & in_ready, register tensors_in into tensors_out and go to MUL.
- MUL: register the six products xx·yy, xy·xy, xy·yt, yy·xt, xy·xt, xx·yt. Go to DET.
- DET: register det, |nx|<<FRAC_BITS, |ny|<<FRAC_BITS and the sign bits of nx and ny.
  - If det < MIN_DET (signed compare): go to DONE with vx = vy = 0, singular = 1, saturated = 0.
  - Otherwise clear the divider counter and go to DIV.
- DIV: two restoring dividers run in parallel against the shared divisor det. Each produces one quotient bit per cycle, MSB first.
  - After DIV_CYCLES iterations, go to DONE.
- Entering DONE from DIV: the magnitude quotient is clamped to 2^(TENSOR_WIDTH-1)−1, then the sign is applied.
  - Range is symmetric: [−(2^(TW−1)−1), +(2^(TW−1)−1)].
  - Rounding is truncation toward zero.
  - saturated = 1 if either quotient clamped.
- DONE: out_valid = 1. vx, vy, singular, saturated and tensors_out are held stable.
  - On out_ready, go to IDLE.
- One transaction in flight at a time. No input buffering.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, vx 0, vy 0, singular 0, saturated 0, tensors_out 0. All internal registers 0.
- Latency (accept edge to out_valid high):
  - Non-singular: DIV_CYCLES+3 cycles (39 at default).
  - Singular: 3 cycles.
- in_ready drops the cycle after accept and stays low until the cycle after the out_valid & out_ready handshake.
- Minimum issue interval:
  - Non-singular: DIV_CYCLES+4 cycles.
  - Singular: 4 cycles.
- Backpressure: with out_valid = 1 and out_ready = 0, all outputs stay bit-stable indefinitely.
- out_ready while out_valid = 0 is ignored.
- in_valid while in_ready = 0 is ignored. The word is not captured.
- rst asserted in any state: the next edge returns to reset values. Any in-flight transaction is discarded and no out_valid is produced for it.
- rst has priority over a simultaneous input or output handshake.

## Test plan
- xx=100, yy=100, xy=0, xt=−50, yt=25 -> det=10000. After 39 cycles: vx=64, vy=−32, singular=0, saturated=0, tensors_out equals the input.
- xx=yy=xy=10 (det=0), xt=5 -> 3 cycles later out_valid with vx=vy=0, singular=1. in_ready returns 1 the cycle after out_ready.
- xx=yy=1, xy=0, xt=−8000, yt=0 -> vx=8191, vy=0, saturated=1. With xt=+8000: vx=−8191, saturated=1.
- xx=yy=3, xy=0, xt=−1, yt=1 -> vx=42, vy=−42. Checks truncation toward zero, not rounding.
- Hold out_ready=0 for 10 cycles after out_valid -> all outputs stable, in_ready=0, a new in_valid is not captured. Release -> one handshake, then IDLE.
- Assert rst for 1 cycle during DIV (cycle 20 after accept) -> all outputs at reset values next cycle. No out_valid for that word. A following word is processed normally.
